// File: rtl/burst_line_pkg.sv
// Shared constants and FSM encoding for the line-granular burst RAM requester.
package burst_line_pkg;
  localparam int BL_ADDR_BITWIDTH  = 4;
  localparam int BL_DATA_BITWIDTH  = 64;
  localparam int BL_BURST_COUNT    = 4;
  localparam int BEAT_IDX_BITWIDTH = $clog2(BL_BURST_COUNT);

  localparam logic RAM_CMD_READ  = 1'b0;
  localparam logic RAM_CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_BURST   = 3'd1,
    ST_RD_CMD     = 3'd2,
    ST_RD_COLLECT = 3'd3,
    ST_RESP       = 3'd4
  } state_e;
endpackage

// File: rtl/burst_line_if.sv
// Client request/response plus RAM command/burst signals of the line port.
interface burst_line_if
  import burst_line_pkg::*;
#(
  parameter int ADDR_BITWIDTH = BL_ADDR_BITWIDTH,
  parameter int DATA_BITWIDTH = BL_DATA_BITWIDTH,
  parameter int BURST_COUNT   = BL_BURST_COUNT
);
  localparam int LINE_BITWIDTH      = DATA_BITWIDTH * BURST_COUNT;
  localparam int LINE_ADDR_BITWIDTH = ADDR_BITWIDTH - $clog2(BURST_COUNT);

  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic [LINE_ADDR_BITWIDTH-1:0] req_line_addr;
  logic [LINE_BITWIDTH-1:0]      req_wr_line;
  logic [LINE_BITWIDTH/8-1:0]    req_wr_strb;
  logic                          resp_valid;
  logic [LINE_BITWIDTH-1:0]      resp_rd_line;
  logic                          err;
  logic                          ram_cmd;
  logic                          ram_cmd_en;
  logic [ADDR_BITWIDTH-1:0]      ram_addr;
  logic [DATA_BITWIDTH-1:0]      ram_wr_data;
  logic [DATA_BITWIDTH/8-1:0]    ram_data_mask;
  logic [DATA_BITWIDTH-1:0]      ram_rd_data;
  logic                          ram_rd_data_valid;
  logic                          ram_busy;

  modport slave (
    input  req_valid, req_write, req_line_addr, req_wr_line, req_wr_strb,
    input  ram_rd_data, ram_rd_data_valid, ram_busy,
    output req_ready, resp_valid, resp_rd_line, err,
    output ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
  );

  modport master (
    output req_valid, req_write, req_line_addr, req_wr_line, req_wr_strb,
    output ram_rd_data, ram_rd_data_valid, ram_busy,
    input  req_ready, resp_valid, resp_rd_line, err,
    input  ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
  );
endinterface

// File: rtl/burst_line_port_buffer.sv
// Beat-slot line register: loads whole lines or single beats, exposes line and one selected beat.
module burst_line_buffer
  import burst_line_pkg::*;
#(
  parameter int DATA_BITWIDTH = BL_DATA_BITWIDTH,
  parameter int BURST_COUNT   = BL_BURST_COUNT,
  localparam int IDX_W        = $clog2(BURST_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [BURST_COUNT-1:0]                    i_we,
  input  logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]                          i_sel,
  output logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] o_line,
  output logic [DATA_BITWIDTH-1:0]                  o_beat
);
  logic [DATA_BITWIDTH-1:0] r_slot [BURST_COUNT];

  for (genvar g = 0; g < BURST_COUNT; g++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_slot[g] <= '0;
      else if (i_we[g]) r_slot[g] <= i_wdata[g];
    end
    assign o_line[g] = r_slot[g];
  end

  assign o_beat = r_slot[i_sel];
endmodule

// File: rtl/burst_line_port.sv
// Line requester: turns one 256-bit read/write into a RAM command plus 4-beat burst.
module burst_line_port
  import burst_line_pkg::*;
#(
  parameter int ADDR_BITWIDTH = BL_ADDR_BITWIDTH,
  parameter int DATA_BITWIDTH = BL_DATA_BITWIDTH,
  parameter int BURST_COUNT   = BL_BURST_COUNT
) (
  input logic         clk,
  input logic         rst_n,
  burst_line_if.slave bus
);
  localparam int LINE_BITWIDTH = DATA_BITWIDTH * BURST_COUNT;
  localparam int IDX_W         = $clog2(BURST_COUNT);
  localparam int STRB_W        = DATA_BITWIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_COUNT - 1);

  state_e                                    r_state;
  logic                                      r_live, r_busy_d, r_err, r_resp_valid;
  logic                                      r_cmd, r_cmd_en;
  logic [ADDR_BITWIDTH-1:0]                  r_addr;
  logic [DATA_BITWIDTH-1:0]                  r_wr_data;
  logic [STRB_W-1:0]                         r_mask;
  logic [IDX_W-1:0]                          r_cnt;
  logic [BURST_COUNT-1:0][STRB_W-1:0]        r_strb;
  logic [LINE_BITWIDTH-1:0]                  r_rd_line;

  logic                                      w_accept, w_beat_in;
  logic [BURST_COUNT-1:0]                    w_buf_we;
  logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] w_buf_wdata, w_buf_line, w_req_line;
  logic [BURST_COUNT-1:0][STRB_W-1:0]        w_req_strb;
  logic [DATA_BITWIDTH-1:0]                  w_buf_beat;

  assign w_req_line    = bus.req_wr_line;
  assign w_req_strb    = bus.req_wr_strb;
  // r_live keeps req_ready low while reset is asserted.
  assign bus.req_ready = r_live && (r_state == ST_IDLE) && !bus.ram_busy;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_beat_in     = (r_state == ST_RD_COLLECT) && bus.ram_rd_data_valid;

  // Same buffer serializes write lines (loaded whole on accept) and assembles read beats.
  always_comb begin
    w_buf_we    = '0;
    w_buf_wdata = {BURST_COUNT{bus.ram_rd_data}};
    if (w_accept && bus.req_write) begin
      w_buf_we    = '1;
      w_buf_wdata = w_req_line;
    end else if (w_beat_in) begin
      w_buf_we[r_cnt] = 1'b1;
    end
  end

  burst_line_buffer #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .BURST_COUNT   (BURST_COUNT)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_buf_we),
    .i_wdata (w_buf_wdata),
    .i_sel   (r_cnt),
    .o_line  (w_buf_line),
    .o_beat  (w_buf_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_live       <= 1'b0;
      r_busy_d     <= 1'b0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_cmd        <= RAM_CMD_READ;
      r_cmd_en     <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_strb       <= '0;
      r_rd_line    <= '0;
    end else begin
      r_live       <= 1'b1;
      r_busy_d     <= bus.ram_busy;
      r_resp_valid <= 1'b0;
      r_cmd_en     <= 1'b0;
      if (bus.ram_rd_data_valid && r_state != ST_RD_COLLECT) r_err <= 1'b1;
      if (bus.ram_busy && !r_busy_d &&
          (r_state == ST_WR_BURST || r_state == ST_RD_COLLECT)) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_cmd_en <= 1'b1;
          r_cmd    <= bus.req_write ? RAM_CMD_WRITE : RAM_CMD_READ;
          r_addr   <= {bus.req_line_addr, {IDX_W{1'b0}}};
          r_strb   <= w_req_strb;
          if (bus.req_write) begin
            // Beat 0 goes out alongside the command, straight from the request.
            r_wr_data <= w_req_line[0];
            r_mask    <= ~w_req_strb[0];
            r_cnt     <= IDX_W'(1);
            r_state   <= ST_WR_BURST;
          end else begin
            r_cnt   <= '0;
            r_state <= ST_RD_CMD;
          end
        end
        ST_WR_BURST: begin
          if (r_cnt == '0) begin
            r_wr_data    <= '0;
            r_mask       <= '0;
            r_cmd        <= RAM_CMD_READ;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_wr_data <= w_buf_beat;
            r_mask    <= ~r_strb[r_cnt];
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        ST_RD_CMD: r_state <= ST_RD_COLLECT;
        ST_RD_COLLECT: if (bus.ram_rd_data_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_BEAT) begin
            r_rd_line    <= {bus.ram_rd_data, w_buf_line[BURST_COUNT-2:0]};
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_rd_line  = r_rd_line;
  assign bus.err           = r_err;
  assign bus.ram_cmd       = r_cmd;
  assign bus.ram_cmd_en    = r_cmd_en;
  assign bus.ram_addr      = r_addr;
  assign bus.ram_wr_data   = r_wr_data;
  assign bus.ram_data_mask = r_mask;
endmodule

// File: tb/tb_burst_line_port.sv
// Directed + randomized bench for burst_line_port with a behavioural RAM and a line-level reference memory.
module tb_burst_line_port;
  import burst_line_pkg::*;

  localparam int LAW = BL_ADDR_BITWIDTH - BEAT_IDX_BITWIDTH;
  localparam logic [255:0] LINE0 = {64'h7D4E9F2C1B6A3D8F, 64'hA1C3F7E2D5B8A9C4,
                                    64'h9D8E2F17AB4C3E6F, 64'h3F5A2E14B7C6A980};
  localparam logic [255:0] LINE1 = {64'hD4E7F2C5B8A3D6E9, 64'hF8E9D2C3B4A5F6E7,
                                    64'hE1A7D0B5C8F3E6A9, 64'h6C4B9A8D2F5E3C7A};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  burst_line_if bus ();
  burst_line_port dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [63:0]  mem     [16];
  logic [63:0]  ref_mem [16];
  logic [255:0] last_line;
  bit   gaps, inj_valid;
  int   beats_sent = 0, resp_cnt = 0, cmd_en_cnt = 0;

  function automatic logic [63:0] init_word(input int i);
    case (i)
      0: return 64'h3F5A2E14B7C6A980;
      1: return 64'h9D8E2F17AB4C3E6F;
      2: return 64'hA1C3F7E2D5B8A9C4;
      3: return 64'h7D4E9F2C1B6A3D8F;
      4: return 64'h6C4B9A8D2F5E3C7A;
      5: return 64'hE1A7D0B5C8F3E6A9;
      6: return 64'hF8E9D2C3B4A5F6E7;
      7: return 64'hD4E7F2C5B8A3D6E9;
      default: return {16'hC0DE, 16'(i), 16'h5A5A, 16'(i)};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural RAM: samples the port mid-cycle, returns read beats from the next cycle on.
  initial begin : ram_model
    int wr_left, rd_left;
    logic [3:0] wr_ptr, rd_ptr;
    wr_left = 0; rd_left = 0; wr_ptr = '0; rd_ptr = '0;
    for (int i = 0; i < 16; i++) mem[i] = init_word(i);
    bus.ram_rd_data_valid = 1'b0;
    bus.ram_rd_data       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_left = 0; rd_left = 0;
        bus.ram_rd_data_valid = 1'b0;
      end else begin
        resp_cnt   += int'(bus.resp_valid);
        cmd_en_cnt += int'(bus.ram_cmd_en);
        if (bus.ram_cmd_en && bus.ram_cmd) begin
          wr_ptr = bus.ram_addr; wr_left = 4;
        end
        if (wr_left > 0) begin
          for (int b = 0; b < 8; b++)
            if (!bus.ram_data_mask[b]) mem[wr_ptr][8*b +: 8] = bus.ram_wr_data[8*b +: 8];
          wr_ptr++; wr_left--;
        end
        bus.ram_rd_data_valid = inj_valid;
        bus.ram_rd_data       = {$urandom, $urandom};
        if (rd_left > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          bus.ram_rd_data_valid = 1'b1;
          bus.ram_rd_data       = mem[rd_ptr];
          rd_ptr++; rd_left--; beats_sent++;
        end
        if (bus.ram_cmd_en && !bus.ram_cmd) begin
          rd_ptr = bus.ram_addr; rd_left = 4;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic send(input logic wr, input logic [LAW-1:0] line,
                      input logic [255:0] data, input logic [31:0] strb);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_line_addr = line;
    bus.req_wr_line = data; bus.req_wr_strb = strb;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [LAW-1:0] line, input logic [255:0] data,
                          input logic [31:0] strb, input bit pulse_busy);
    logic [7:0] m;
    send(1'b1, line, data, strb);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m = ~strb[8*k +: 8];
      chk("wr_cmd_en", bus.ram_cmd_en, k == 0);
      chk("wr_cmd", bus.ram_cmd, 1'b1);
      if (k == 0) chk("wr_addr", bus.ram_addr, {line, 2'b00});
      chk("wr_data", bus.ram_wr_data, data[64*k +: 64]);
      chk("wr_mask", bus.ram_data_mask, m);
      if (pulse_busy) bus.ram_busy = (k == 0);
    end
    @(negedge clk);
    chk("wr_resp_valid", bus.resp_valid, 1'b1);
    chk("wr_data_idle", bus.ram_wr_data, 64'h0);
    chk("wr_mask_idle", bus.ram_data_mask, 8'h0);
    chk("wr_line_kept", bus.resp_rd_line, last_line);
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 8; b++)
        if (strb[8*k + b]) ref_mem[4*line + k][8*b +: 8] = data[64*k + 8*b +: 8];
    @(negedge clk);
    chk("wr_resp_pulse", bus.resp_valid, 1'b0);
    chk("wr_next_ready", bus.req_ready, 1'b1);
  endtask

  task automatic do_read(input logic [LAW-1:0] line);
    logic [255:0] exp;
    int n, c0, r0;
    for (int k = 0; k < 4; k++) exp[64*k +: 64] = ref_mem[4*line + k];
    send(1'b0, line, '0, '0);
    c0 = cmd_en_cnt; r0 = resp_cnt;
    @(negedge clk);
    chk("rd_cmd_en", bus.ram_cmd_en, 1'b1);
    chk("rd_cmd", bus.ram_cmd, 1'b0);
    chk("rd_addr", bus.ram_addr, {line, 2'b00});
    n = 0;
    while (!bus.resp_valid && n < 60) begin @(negedge clk); n++; end
    chk("rd_resp_valid", bus.resp_valid, 1'b1);
    chk("rd_line", bus.resp_rd_line, exp);
    last_line = exp;
    @(negedge clk); #1;
    chk("rd_resp_pulse", bus.resp_valid, 1'b0);
    chk("rd_cmd_en_pulses", cmd_en_cnt - c0, 1);
    chk("rd_resp_pulses", resp_cnt - r0, 1);
  endtask

  initial begin : stim
    logic [255:0] d;
    logic [63:0]  orig12;
    int n, r0, b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    last_line = '0; gaps = 1'b0; inj_valid = 1'b0;
    rst_n = 1'b0; bus.ram_busy = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_line_addr = '0;
    bus.req_wr_line = '0; bus.req_wr_strb = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_cmd", bus.ram_cmd, 1'b0);
    chk("rst_cmd_en", bus.ram_cmd_en, 1'b0);
    chk("rst_addr", bus.ram_addr, 4'h0);
    chk("rst_wr_data", bus.ram_wr_data, 64'h0);
    chk("rst_mask", bus.ram_data_mask, 8'h0);
    chk("rst_line", bus.resp_rd_line, 256'h0);

    // Release with RAM busy; a pending request must be held off
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_line_addr = 2'd1;
    bus.req_wr_strb = '1; bus.req_wr_line = {8{32'hDEADBEEF}};
    repeat (10) begin
      @(negedge clk);
      chk("busy_req_ready", bus.req_ready, 1'b0);
      chk("busy_cmd_en", bus.ram_cmd_en, 1'b0);
      chk("busy_addr", bus.ram_addr, 4'h0);
      chk("busy_wr_data", bus.ram_wr_data, 64'h0);
      chk("busy_mask", bus.ram_data_mask, 8'h0);
    end
    bus.req_valid = 1'b0; bus.ram_busy = 1'b0;
    @(negedge clk);
    chk("ready_after_busy", bus.req_ready, 1'b1);
    chk("no_side_effect_cmd", bus.ram_cmd_en, 1'b0);

    // Directed reads of the preloaded lines
    do_read(2'd0);
    chk("line0_const", bus.resp_rd_line, LINE0);
    do_read(2'd1);
    chk("line1_const", bus.resp_rd_line, LINE1);

    // Full write then readback
    for (int k = 0; k < 4; k++) d[64*k +: 64] = 64'h1111_1111_1111_1111 * (k + 1);
    do_write(2'd2, d, 32'hFFFF_FFFF, 1'b0);
    do_read(2'd2);
    chk("line2_readback", bus.resp_rd_line, d);

    // Partial write touching only the low 4 bytes of word 12
    orig12 = ref_mem[12];
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write(2'd3, d, 32'h0000_000F, 1'b0);
    chk("word12_partial", mem[12], {orig12[63:32], d[31:0]});
    do_read(2'd3);

    // Stray read beat while idle
    chk("err_before_inject", bus.err, 1'b0);
    @(posedge clk); #1 inj_valid = 1'b1;
    @(posedge clk); #1 inj_valid = 1'b0;
    @(negedge clk);
    chk("err_inject", bus.err, 1'b1);
    repeat (5) @(negedge clk);
    chk("err_sticky", bus.err, 1'b1);

    // Reset in RD_COLLECT after beat 1 aborts silently
    r0 = resp_cnt; b0 = beats_sent;
    send(1'b0, 2'd0, '0, '0);
    n = 0;
    while (beats_sent - b0 < 2 && n < 40) begin @(negedge clk); #1; n++; end
    chk("abort_beats_seen", beats_sent - b0 >= 2, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", bus.resp_valid, 1'b0);
    chk("abort_err", bus.err, 1'b0);
    chk("abort_line", bus.resp_rd_line, 256'h0);
    last_line = '0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_resp", resp_cnt, r0);
    chk("abort_err_low", bus.err, 1'b0);
    do_read(2'd0);
    chk("line0_after_abort", bus.resp_rd_line, LINE0);

    // Randomized traffic with gapped read beats
    gaps = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write(LAW'($urandom_range(0, 3)), d,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom), 1'b0);
      end else begin
        do_read(LAW'($urandom_range(0, 3)));
      end
    end
    chk("err_after_random", bus.err, 1'b0);

    // RAM busy rising mid-burst flags an error
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write(2'd1, d, 32'hFFFF_FFFF, 1'b1);
    chk("err_busy_rise", bus.err, 1'b1);

    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
